bus_arb2: RTL

Two-master round-robin arbiter with an ACK watchdog, sitting between two bus masters and one shared slave port (constant/ID register block and peripherals at 0x0200_01xx). Grants one master at a time, registers its address, write data and WE onto the slave bus, and waits for the slave's ACK. If no ACK arrives within TIMEOUT cycles, it returns an error instead, so unmapped addresses cannot hang a master. Placed in front of the peripheral slave mux.

---
 rtl/bus_arb_pkg.sv | 20 ++
 rtl/bus_watchdog.sv | 26 ++
 rtl/bus_arb2.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared state encoding, response status and defaults for the two-master arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic RSP_OK  = 1'b0;
  localparam logic RSP_ERR = 1'b1;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'h0000_0000;
  localparam int WD_W = 8;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// ACK watchdog: counts BUSY cycles without a slave ACK and flags the last allowed one.
module bus_watchdog
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iClr,
  input  logic iEn,
  output logic oExpire
);

  logic [WD_W-1:0] count;

  always_ff @(posedge iCLK) begin
    if (iRST || iClr) begin
      count <= '0;
    end else if (iEn) begin
      count <= count + 1'b1;
    end
  end

  assign oExpire = (count == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/bus_arb2.sv
// Two-master round-robin arbiter onto one slave port, with an ACK watchdog that
// turns a missing slave ACK into a one-cycle error response.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no transfer; pick a winner from the pending strobes
//   ST_BUSY | slave strobe high, waiting for ACK or watchdog expiry
//   ST_RESP | one-cycle ACK/ERR pulse to the granted master
module bus_arb2
  import bus_arb_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = DEFAULT_ERR_DATA
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iM0_ADR,
  input  logic [31:0] iM0_DAT,
  input  logic        iM0_STB,
  input  logic        iM0_WE,
  output logic [31:0] oM0_DAT,
  output logic        oM0_ACK,
  output logic        oM0_ERR,
  input  logic [31:0] iM1_ADR,
  input  logic [31:0] iM1_DAT,
  input  logic        iM1_STB,
  input  logic        iM1_WE,
  output logic [31:0] oM1_DAT,
  output logic        oM1_ACK,
  output logic        oM1_ERR,
  output logic [31:0] oS_ADR,
  output logic [31:0] oS_DAT,
  output logic        oS_STB,
  output logic        oS_WE,
  input  logic [31:0] iS_DAT,
  input  logic        iS_ACK,
  output logic [1:0]  oGNT,
  output logic [7:0]  oERR_CNT
);

  state_t      state;
  logic        last;
  logic        anyReq;
  logic        pickM1;
  logic        wdClr;
  logic        wdEn;
  logic        wdExpire;
  logic        busyRsp;
  logic [31:0] rspData;

  assign anyReq = iM0_STB | iM1_STB;
  // M1 wins when it is the only requester, or on a tie when M0 was served last.
  assign pickM1 = iM1_STB & (~iM0_STB | ~last);

  assign wdClr   = (state == ST_IDLE);
  assign wdEn    = (state == ST_BUSY) & ~iS_ACK & ~wdExpire;
  assign busyRsp = iS_ACK ? RSP_OK : RSP_ERR;
  assign rspData = oS_WE ? 32'h0 : ((busyRsp == RSP_OK) ? iS_DAT : ERR_DATA);

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iClr   (wdClr),
    .iEn    (wdEn),
    .oExpire(wdExpire)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= ST_IDLE;
      last     <= 1'b1;
      oS_ADR   <= '0;
      oS_DAT   <= '0;
      oS_STB   <= 1'b0;
      oS_WE    <= 1'b0;
      oGNT     <= '0;
      oM0_DAT  <= '0;
      oM0_ACK  <= 1'b0;
      oM0_ERR  <= 1'b0;
      oM1_DAT  <= '0;
      oM1_ACK  <= 1'b0;
      oM1_ERR  <= 1'b0;
      oERR_CNT <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (anyReq) begin
            state  <= ST_BUSY;
            last   <= pickM1;
            oGNT   <= pickM1 ? 2'b10 : 2'b01;
            oS_STB <= 1'b1;
            oS_ADR <= pickM1 ? iM1_ADR : iM0_ADR;
            oS_DAT <= pickM1 ? iM1_DAT : iM0_DAT;
            oS_WE  <= pickM1 ? iM1_WE : iM0_WE;
          end
        end
        ST_BUSY: begin
          // ACK in the expiry cycle still counts as a good completion.
          if (iS_ACK || wdExpire) begin
            state  <= ST_RESP;
            oS_STB <= 1'b0;
            oS_ADR <= '0;
            oS_DAT <= '0;
            oS_WE  <= 1'b0;
            if (last) begin
              oM1_DAT <= rspData;
              oM1_ACK <= (busyRsp == RSP_OK);
              oM1_ERR <= (busyRsp == RSP_ERR);
            end else begin
              oM0_DAT <= rspData;
              oM0_ACK <= (busyRsp == RSP_OK);
              oM0_ERR <= (busyRsp == RSP_ERR);
            end
            if (busyRsp == RSP_ERR) begin
              oERR_CNT <= satInc8(oERR_CNT);
            end
          end
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          oGNT    <= '0;
          oM0_DAT <= '0;
          oM0_ACK <= 1'b0;
          oM0_ERR <= 1'b0;
          oM1_DAT <= '0;
          oM1_ACK <= 1'b0;
          oM1_ERR <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
